// File: rtl/hubris_arb_pkg.sv
// Shared types and constants for the Hubris unified-memory arbiter.
package hubris_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IF = 2'd1,
    ST_WAIT_DM = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Same byte-count encoding as the register-file write width.
  localparam logic [3:0] WIDTH_BYTE = 4'd1;
  localparam logic [3:0] WIDTH_HALF = 4'd2;
  localparam logic [3:0] WIDTH_WORD = 4'd4;

  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      ST_WAIT_IF: state_owner = OWN_IF;
      ST_WAIT_DM: state_owner = OWN_DM;
      default:    state_owner = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hubris_arb_starve_ctr.sv
// Saturating up-counter with clear; sat flags that IF has waited LIMIT DM grants.
module hubris_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !sat)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hubris_mem_arbiter.sv
// Shares one single-port memory between IF and MEM-stage requesters.
// HUBRIS_ARB_ANTISTARVE_EN: force an IF issue after STARVE_LIMIT DM grants.
//
// state      | meaning
// IDLE       | nothing outstanding; issue allowed
// WAIT_IF    | fetch outstanding; issue allowed on its mem_rvalid
// WAIT_DM    | data access outstanding; issue allowed on its mem_rvalid
module hubris_mem_arbiter
  import hubris_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [3:0]            dm_width,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_width,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  proto_err
);

  arb_state_e state_q, state_d;
  logic       drain_q, drain_d;
  logic       proto_err_q, proto_err_d;
  logic       issue_ok, force_if, sel_dm, sel_if;
  owner_e     owner;

  assign issue_ok = !reset && ((state_q == ST_IDLE) || mem_rvalid);

`ifdef HUBRIS_ARB_ANTISTARVE_EN
  logic starve_sat;

  hubris_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (dm_gnt && if_req),
    .clr   (if_gnt),
    .sat   (starve_sat)
  );

  assign force_if = starve_sat && if_req;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_if = 1'b0;
`endif

  assign sel_dm  = issue_ok && dm_req && !force_if;
  assign sel_if  = issue_ok && if_req && !sel_dm;
  assign mem_req = sel_dm || sel_if;
  assign dm_gnt  = sel_dm && mem_ready;
  assign if_gnt  = sel_if && mem_ready;

  always_comb begin
    mem_we    = 1'b0;
    mem_width = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_dm) begin
      mem_we    = dm_we;
      mem_width = dm_width;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (sel_if) begin
      mem_width = WIDTH_WORD;
      mem_addr  = if_addr;
    end
  end

  // Drain is only ever set while IDLE, so state alone identifies the owner.
  assign owner     = state_owner(state_q);
  assign if_rvalid = !reset && mem_rvalid && (owner == OWN_IF);
  assign dm_rvalid = !reset && mem_rvalid && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
  assign proto_err = proto_err_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    proto_err_d = proto_err_q;
    if (mem_rvalid && (state_q == ST_IDLE) && !drain_q)
      proto_err_d = 1'b1;
    if (mem_rvalid || if_gnt || dm_gnt)
      drain_d = 1'b0;
    if (dm_gnt)
      state_d = ST_WAIT_DM;
    else if (if_gnt)
      state_d = ST_WAIT_IF;
    else if (mem_rvalid)
      state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_hubris_mem_arbiter.sv
// Scoreboard bench for hubris_mem_arbiter; anti-starvation pattern runs when
// HUBRIS_ARB_ANTISTARVE_EN is defined.
module tb_hubris_mem_arbiter;

  localparam logic [1:0] K_IF_GNT = 2'd0;
  localparam logic [1:0] K_DM_GNT = 2'd1;
  localparam logic [1:0] K_IF_RV  = 2'd2;
  localparam logic [1:0] K_DM_RV  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
    logic        we;
    logic [3:0]  width;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_width;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [3:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        proto_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hubris_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_width(dm_width), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] val,
                      input logic we, input logic [3:0] width);
    exp_t e;
    e.kind = kind; e.val = val; e.we = we; e.width = width;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: responses are popped before grants, matching push order.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid || dm_rvalid) begin
      chk("rv_both", {63'd0, if_rvalid && dm_rvalid}, 64'd0);
      chk("rv_other_rdata", {32'd0, if_rvalid ? dm_rdata : if_rdata}, 64'd0);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: got if=%0b dm=%0b expected none at %0t",
                 if_rvalid, dm_rvalid, $time);
      end else begin
        e = q.pop_front();
        chk("rv_kind", {62'd0, (if_rvalid ? K_IF_RV : K_DM_RV)}, {62'd0, e.kind});
        chk("rv_rdata", {32'd0, (if_rvalid ? if_rdata : dm_rdata)}, {32'd0, e.val});
      end
    end
    if (if_gnt || dm_gnt) begin
      chk("gnt_both", {63'd0, if_gnt && dm_gnt}, 64'd0);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_gnt: got if=%0b dm=%0b expected none at %0t",
                 if_gnt, dm_gnt, $time);
      end else begin
        e = q.pop_front();
        chk("gnt_kind", {62'd0, (dm_gnt ? K_DM_GNT : K_IF_GNT)}, {62'd0, e.kind});
        chk("gnt_addr", {32'd0, mem_addr}, {32'd0, e.val});
        chk("gnt_we", {63'd0, mem_we}, {63'd0, e.we});
        chk("gnt_width", {60'd0, mem_width}, {60'd0, e.width});
        chk("gnt_mem_req", {63'd0, mem_req}, 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_width = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) cyc();
    #3;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
    reset = 1'b0;
    cyc();
    #3;
    chk("post_rst_proto_err", {63'd0, proto_err}, 64'd0);
    chk("post_rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("post_rst_rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);

    // Single fetch; reset drain flag is cleared by the grant.
    cyc();
    if_req = 1; if_addr = 32'h10; mem_ready = 1;
    push(K_IF_GNT, 32'h10, 1'b0, 4'd4);
    #3;
    chk("if_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    cyc();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    push(K_IF_RV, 32'h0000_0013, 1'b0, 4'd0);
    cyc();
    mem_rvalid = 0;

    // Simultaneous requests: DM first, IF granted on the DM response cycle.
    dm_req = 1; dm_we = 0; dm_width = 4; dm_addr = 32'h100;
    if_req = 1; if_addr = 32'h14;
    push(K_DM_GNT, 32'h100, 1'b0, 4'd4);
    cyc();
    dm_req = 0;
    #3;
    chk("if_waits_gnt", {63'd0, if_gnt}, 64'd0);
    chk("if_waits_mem_req", {63'd0, mem_req}, 64'd0);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    push(K_DM_RV, 32'hCAFE_0001, 1'b0, 4'd0);
    push(K_IF_GNT, 32'h14, 1'b0, 4'd4);
    cyc();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0017;
    push(K_IF_RV, 32'h0000_0017, 1'b0, 4'd0);
    cyc();
    mem_rvalid = 0;

    // Memory backpressure on a word store.
    mem_ready = 0;
    dm_req = 1; dm_we = 1; dm_width = 4; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_gnt", {63'd0, dm_gnt}, 64'd0);
      chk("stall_mem_req", {63'd0, mem_req}, 64'd1);
      chk("stall_mem_addr", {32'd0, mem_addr}, 64'h200);
      chk("stall_mem_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
      chk("stall_mem_we", {63'd0, mem_we}, 64'd1);
      cyc();
    end
    mem_ready = 1;
    push(K_DM_GNT, 32'h200, 1'b1, 4'd4);
    cyc();
    dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    push(K_DM_RV, 32'h0, 1'b0, 4'd0);
    cyc();
    mem_rvalid = 0;

    // Spurious response in IDLE.
    mem_rvalid = 1; mem_rdata = 32'h55;
    #3;
    chk("proto_err_before_edge", {63'd0, proto_err}, 64'd0);
    cyc();
    mem_rvalid = 0;
    #3;
    chk("proto_err_set", {63'd0, proto_err}, 64'd1);
    cyc(); cyc();
    #3;
    chk("proto_err_sticky", {63'd0, proto_err}, 64'd1);

    // Reset abandons an outstanding load; its late response is drained.
    cyc();
    dm_req = 1; dm_we = 0; dm_width = 4; dm_addr = 32'h300;
    push(K_DM_GNT, 32'h300, 1'b0, 4'd4);
    cyc();
    dm_req = 0; reset = 1;
    cyc();
    reset = 0; mem_rvalid = 1; mem_rdata = 32'h99;
    #3;
    chk("drain_proto_err_cleared", {63'd0, proto_err}, 64'd0);
    cyc();
    mem_rvalid = 0;
    #3;
    chk("drain_no_proto_err", {63'd0, proto_err}, 64'd0);
    cyc();
    if_req = 1; if_addr = 32'h40;
    push(K_IF_GNT, 32'h40, 1'b0, 4'd4);
    cyc();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    push(K_IF_RV, 32'h1234, 1'b0, 4'd0);
    cyc();
    mem_rvalid = 0;
    cyc();

`ifdef HUBRIS_ARB_ANTISTARVE_EN
    // Both held with single-cycle memory: DM,DM,DM,DM,IF repeating.
    begin
      logic prev_if, is_if;
      prev_if = 1'b0;
      dm_req = 1; dm_we = 0; dm_width = 4; dm_addr = 32'h400;
      if_req = 1; if_addr = 32'h50;
      for (int i = 0; i < 10; i++) begin
        is_if = ((i % 5) == 4);
        if (i > 0) begin
          mem_rvalid = 1; mem_rdata = 32'h1000 + i;
          push(prev_if ? K_IF_RV : K_DM_RV, 32'h1000 + i, 1'b0, 4'd0);
        end
        if (is_if) push(K_IF_GNT, 32'h50, 1'b0, 4'd4);
        else       push(K_DM_GNT, 32'h400, 1'b0, 4'd4);
        prev_if = is_if;
        cyc();
      end
      dm_req = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 32'h2000;
      push(prev_if ? K_IF_RV : K_DM_RV, 32'h2000, 1'b0, 4'd0);
      cyc();
      mem_rvalid = 0;
      cyc();
    end
`endif

    cyc(); cyc();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
